// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: op classes, decoder field codes and FSM states.
package alu_pkg;

  typedef enum logic [3:0] {
    ADD, SUB, AND, OR, XOR, NOR, SLT, SLTU, SLL, SRL, SRA, MULTU, ILL
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE, MUL, DONE
  } state_e;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ILL   = 2'b11;

  localparam logic [5:0] FUNCT_ADD   = 6'b100000;
  localparam logic [5:0] FUNCT_SUB   = 6'b100010;
  localparam logic [5:0] FUNCT_AND   = 6'b100100;
  localparam logic [5:0] FUNCT_OR    = 6'b100101;
  localparam logic [5:0] FUNCT_XOR   = 6'b100110;
  localparam logic [5:0] FUNCT_NOR   = 6'b100111;
  localparam logic [5:0] FUNCT_SLT   = 6'b101010;
  localparam logic [5:0] FUNCT_SLTU  = 6'b101011;
  localparam logic [5:0] FUNCT_SLL   = 6'b000000;
  localparam logic [5:0] FUNCT_SRL   = 6'b000010;
  localparam logic [5:0] FUNCT_SRA   = 6'b000011;
  localparam logic [5:0] FUNCT_MULTU = 6'b011001;

  // multu only decodes as legal when the multiplier is built in.
  function automatic alu_op_e decode_op(input logic [1:0] aluop, input logic [5:0] funct,
                                        input logic mul_en);
    alu_op_e op;
    op = ILL;
    case (aluop)
      ALUOP_ADD: op = ADD;
      ALUOP_SUB: op = SUB;
      ALUOP_RTYPE: begin
        case (funct)
          FUNCT_ADD:   op = ADD;
          FUNCT_SUB:   op = SUB;
          FUNCT_AND:   op = AND;
          FUNCT_OR:    op = OR;
          FUNCT_XOR:   op = XOR;
          FUNCT_NOR:   op = NOR;
          FUNCT_SLT:   op = SLT;
          FUNCT_SLTU:  op = SLTU;
          FUNCT_SLL:   op = SLL;
          FUNCT_SRL:   op = SRL;
          FUNCT_SRA:   op = SRA;
          FUNCT_MULTU: op = mul_en ? MULTU : ILL;
          default:     op = ILL;
        endcase
      end
      default: op = ILL;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_op_core.sv
// Combinational datapath for every single-cycle ALU operation.
module alu_op_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  alu_op_e            op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [WIDTH-1:0]   result
);

  localparam int SHW = $clog2(WIDTH);

  logic [SHW-1:0] shamt;
  assign shamt = b[SHW-1:0];

  // MULTU and ILL fall to zero; illegal requests must report result 0.
  always_comb begin
    result = '0;
    case (op)
      ADD:     result = a + b;
      SUB:     result = a - b;
      AND:     result = a & b;
      OR:      result = a | b;
      XOR:     result = a ^ b;
      NOR:     result = ~(a | b);
      SLT:     result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      SLTU:    result = {{(WIDTH-1){1'b0}}, (a < b)};
      SLL:     result = a << shamt;
      SRL:     result = a >> shamt;
      SRA:     result = $signed(a) >>> shamt;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_seq_unit.sv
// Sequenced ALU: single-cycle ops via alu_op_core, unsigned multiply by iterative shift-add.
module alu_seq_unit
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       aluop,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic             zero,
  output logic             busy,
  output logic             done,
  output logic             illegal
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_e             state;
  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc_step;
  logic [WIDTH-1:0]   core_result;
  alu_op_e            op;

  assign op = decode_op(aluop, funct, MUL_EN);

  alu_op_core #(.WIDTH(WIDTH)) u_core (
    .op     (op),
    .a      (a),
    .b      (b),
    .result (core_result)
  );

  assign acc_step = mplier[0] ? (acc + mcand) : acc;
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);

  // Multiplicand shifts left while the multiplier drains LSB first; the last step publishes the sum.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      result  <= '0;
      hi      <= '0;
      zero    <= 1'b0;
      illegal <= 1'b0;
      count   <= '0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (op == MULTU) begin
              mcand  <= {{WIDTH{1'b0}}, a};
              mplier <= b;
              acc    <= '0;
              count  <= CW'(WIDTH);
              state  <= MUL;
            end else begin
              result  <= core_result;
              hi      <= '0;
              zero    <= (core_result == '0);
              illegal <= (op == ILL);
              state   <= DONE;
            end
          end
        end
        MUL: begin
          acc    <= acc_step;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count - 1'b1;
          if (count == CW'(1)) begin
            result  <= acc_step[WIDTH-1:0];
            hi      <= acc_step[2*WIDTH-1:WIDTH];
            zero    <= (acc_step[WIDTH-1:0] == '0);
            illegal <= 1'b0;
            state   <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_unit.sv
// Directed bench for alu_seq_unit: 32-bit, 32-bit without multiplier, and 8-bit builds.
module tb_alu_seq_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start32, start_nm, start8;
  logic [1:0]  aluop;
  logic [5:0]  funct;
  logic [31:0] a, b;

  logic [31:0] result32, hi32, result_nm, hi_nm;
  logic [7:0]  result8, hi8;
  logic        zero32, busy32, done32, illegal32;
  logic        zero_nm, busy_nm, done_nm, illegal_nm;
  logic        zero8, busy8, done8, illegal8;

  int passed = 0;
  int total  = 0;

  typedef struct {
    string       name;
    logic [1:0]  aluop;
    logic [5:0]  funct;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_result;
    logic        exp_zero;
    logic        exp_illegal;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  alu_seq_unit #(.WIDTH(32), .MUL_EN(1'b1)) dut32 (
    .clk(clk), .reset(reset), .start(start32), .aluop(aluop), .funct(funct),
    .a(a), .b(b), .result(result32), .hi(hi32), .zero(zero32),
    .busy(busy32), .done(done32), .illegal(illegal32)
  );

  alu_seq_unit #(.WIDTH(32), .MUL_EN(1'b0)) dut_nm (
    .clk(clk), .reset(reset), .start(start_nm), .aluop(aluop), .funct(funct),
    .a(a), .b(b), .result(result_nm), .hi(hi_nm), .zero(zero_nm),
    .busy(busy_nm), .done(done_nm), .illegal(illegal_nm)
  );

  alu_seq_unit #(.WIDTH(8), .MUL_EN(1'b1)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .aluop(aluop), .funct(funct),
    .a(a[7:0]), .b(b[7:0]), .result(result8), .hi(hi8), .zero(zero8),
    .busy(busy8), .done(done8), .illegal(illegal8)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual === expected) passed++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  task automatic addVec(input string name, input logic [1:0] op, input logic [5:0] fn,
                        input logic [31:0] va, input logic [31:0] vb, input logic [31:0] res,
                        input logic z, input logic ill);
    vec_t v;
    v.name = name; v.aluop = op; v.funct = fn; v.a = va; v.b = vb;
    v.exp_result = res; v.exp_zero = z; v.exp_illegal = ill;
    vecs.push_back(v);
  endtask

  // Drives one request for a full cycle; returns at the negedge after the accepting edge.
  task automatic applyStimulus(input int which, input logic [1:0] op, input logic [5:0] fn,
                               input logic [31:0] va, input logic [31:0] vb);
    @(negedge clk);
    aluop = op; funct = fn; a = va; b = vb;
    start32  = (which == 0);
    start_nm = (which == 1);
    start8   = (which == 2);
    @(negedge clk);
    start32 = 1'b0; start_nm = 1'b0; start8 = 1'b0;
  endtask

  initial begin
    int done_cycle;
    int busy_bad;

    reset = 1'b1;
    start32 = 1'b0; start_nm = 1'b0; start8 = 1'b0;
    aluop = 2'b00; funct = 6'b0; a = '0; b = '0;

    addVec("sub_rtype",  2'b10, 6'b100010, 32'd5,        32'd7,        32'hFFFFFFFE, 1'b0, 1'b0);
    addVec("add_aluop",  2'b00, 6'b000000, 32'd3,        32'd4,        32'd7,        1'b0, 1'b0);
    addVec("sub_aluop0", 2'b01, 6'b000000, 32'd10,       32'd10,       32'd0,        1'b1, 1'b0);
    addVec("and",        2'b10, 6'b100100, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0);
    addVec("or",         2'b10, 6'b100101, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0, 1'b0);
    addVec("xor",        2'b10, 6'b100110, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 1'b0);
    addVec("nor",        2'b10, 6'b100111, 32'hF0F0F0F0, 32'hFF00FF00, 32'h000F000F, 1'b0, 1'b0);
    addVec("sra",        2'b10, 6'b000011, 32'h80000000, 32'd4,        32'hF8000000, 1'b0, 1'b0);
    addVec("slt",        2'b10, 6'b101010, 32'hFFFFFFFF, 32'd1,        32'd1,        1'b0, 1'b0);
    addVec("sltu",       2'b10, 6'b101011, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b1, 1'b0);
    addVec("sll",        2'b10, 6'b000000, 32'd1,        32'd31,       32'h80000000, 1'b0, 1'b0);
    addVec("srl_wrap",   2'b10, 6'b000010, 32'h80000000, 32'd36,       32'h08000000, 1'b0, 1'b0);
    addVec("ill_aluop",  2'b11, 6'b100000, 32'd9,        32'd9,        32'd0,        1'b1, 1'b1);
    addVec("add_wrap",   2'b10, 6'b100000, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b1, 1'b0);
    addVec("sll_big",    2'b10, 6'b000000, 32'h0000FFFF, 32'd8,        32'h00FFFF00, 1'b0, 1'b0);
    addVec("ill_funct",  2'b10, 6'b111111, 32'd9,        32'd9,        32'd0,        1'b1, 1'b1);

    #12;
    checkOutput("rst_result", 64'(result32), 64'h0);
    checkOutput("rst_hi",     64'(hi32),     64'h0);
    checkOutput("rst_flags",  {60'h0, zero32, busy32, done32, illegal32}, 64'h0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(0, vecs[i].aluop, vecs[i].funct, vecs[i].a, vecs[i].b);
      checkOutput({vecs[i].name, "_done"},    64'(done32),    64'h1);
      checkOutput({vecs[i].name, "_result"},  64'(result32),  64'(vecs[i].exp_result));
      checkOutput({vecs[i].name, "_hi"},      64'(hi32),      64'h0);
      checkOutput({vecs[i].name, "_zero"},    64'(zero32),    64'(vecs[i].exp_zero));
      checkOutput({vecs[i].name, "_illegal"}, 64'(illegal32), 64'(vecs[i].exp_illegal));
      @(negedge clk);
      checkOutput({vecs[i].name, "_idle"},    {62'h0, busy32, done32}, 64'h0);
      checkOutput({vecs[i].name, "_hold"},    64'(result32),  64'(vecs[i].exp_result));
    end

    // Multiply FFFFFFFF * 2 with ignored start pulses carrying different operands.
    applyStimulus(0, 2'b10, 6'b011001, 32'hFFFFFFFF, 32'd2);
    done_cycle = 0;
    busy_bad = 0;
    for (int k = 1; k <= 40; k++) begin
      if (!busy32) busy_bad++;
      if (done32) begin
        done_cycle = k;
        break;
      end
      start32 = (k == 5 || k == 6);
      aluop = 2'b00; funct = 6'b0; a = 32'd1; b = 32'd1;
      @(negedge clk);
    end
    start32 = 1'b0;
    checkOutput("multu_done_cycle", 64'(done_cycle), 64'd33);
    checkOutput("multu_busy",       64'(busy_bad),   64'd0);
    checkOutput("multu_hi",         64'(hi32),       64'h1);
    checkOutput("multu_result",     64'(result32),   64'hFFFFFFFE);
    checkOutput("multu_zero",       64'(zero32),     64'h0);
    checkOutput("multu_illegal",    64'(illegal32),  64'h0);
    @(negedge clk);
    checkOutput("multu_after",      {62'h0, busy32, done32}, 64'h0);
    checkOutput("multu_hold_hi",    64'(hi32),       64'h1);

    // Abort a multiply with reset asserted between clock edges.
    applyStimulus(0, 2'b10, 6'b011001, 32'd7, 32'd3);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checkOutput("abort_flags",  {62'h0, busy32, done32}, 64'h0);
    checkOutput("abort_result", 64'(result32), 64'h0);
    checkOutput("abort_hi",     64'(hi32),     64'h0);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(0, 2'b00, 6'b0, 32'd3, 32'd4);
    checkOutput("post_reset_done",   64'(done32),   64'h1);
    checkOutput("post_reset_result", 64'(result32), 64'd7);

    // 2^16 * 2^16: product lands entirely in hi, low half is zero.
    applyStimulus(0, 2'b10, 6'b011001, 32'h00010000, 32'h00010000);
    done_cycle = 0;
    for (int k = 1; k <= 40; k++) begin
      if (done32) begin
        done_cycle = k;
        break;
      end
      @(negedge clk);
    end
    checkOutput("multu2_done_cycle", 64'(done_cycle), 64'd33);
    checkOutput("multu2_hi",         64'(hi32),       64'h1);
    checkOutput("multu2_result",     64'(result32),   64'h0);
    checkOutput("multu2_zero",       64'(zero32),     64'h1);

    applyStimulus(1, 2'b10, 6'b011001, 32'd6, 32'd7);
    checkOutput("nomul_done",    64'(done_nm),    64'h1);
    checkOutput("nomul_illegal", 64'(illegal_nm), 64'h1);
    checkOutput("nomul_result",  64'(result_nm),  64'h0);
    checkOutput("nomul_zero",    64'(zero_nm),    64'h1);

    applyStimulus(2, 2'b00, 6'b0, 32'h000000FF, 32'd1);
    checkOutput("w8_add_done",   64'(done8),   64'h1);
    checkOutput("w8_add_result", 64'(result8), 64'h0);
    checkOutput("w8_add_zero",   64'(zero8),   64'h1);
    applyStimulus(2, 2'b10, 6'b000000, 32'h00000001, 32'd9);
    checkOutput("w8_sll_result", 64'(result8), 64'h2);
    checkOutput("w8_sll_zero",   64'(zero8),   64'h0);
    applyStimulus(2, 2'b10, 6'b011001, 32'h000000FF, 32'h000000FF);
    done_cycle = 0;
    for (int k = 1; k <= 20; k++) begin
      if (done8) begin
        done_cycle = k;
        break;
      end
      @(negedge clk);
    end
    checkOutput("w8_mul_cycle",  64'(done_cycle), 64'd9);
    checkOutput("w8_mul_hi",     64'(hi8),        64'hFE);
    checkOutput("w8_mul_result", 64'(result8),    64'h01);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/alu_seq_unit.md
ALU_SEQ_UNIT -- requirements
Module: alu_seq_unit

Interface
REQ-001 Parameter: WIDTH, 32, datapath width in bits (legal 8..64, power of two).
REQ-002 Parameter: MUL_EN, 1, 1 enables the iterative unsigned multiply; 0 makes multu illegal.
REQ-003 One clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  asynchronous active-high reset.
REQ-006 start  input  1  request; sampled only in IDLE.
REQ-007 aluop  input  2  main-decoder op class.
REQ-008 funct  input  6  R-type function field, used when aluop=10.
REQ-009 a, b  input  WIDTH each  operands, captured at the accepting edge.
REQ-010 result  output  WIDTH  registered result, low product half for multu.
REQ-011 hi  output  WIDTH  registered high product half; 0 for non-multiply ops.
REQ-012 zero  output  1  registered (result==0), updated with result.
REQ-013 busy  output  1  high whenever state != IDLE.
REQ-014 done  output  1  one-cycle completion pulse.
REQ-015 illegal  output  1  registered; high with done when the request decoded as illegal.

Function
REQ-016 Decode: aluop 00 add; 01 sub; 11 illegal; 10 by funct: 100000 add, 100010 sub, 100100 and, 100101 or, 100110 xor, 100111 nor, 101010 slt (signed), 101011 sltu, 000000 sll, 000010 srl, 000011 sra, 011001 multu (MUL_EN=1 only); any other funct illegal.
REQ-017 Shift amount is b[$clog2(WIDTH)-1:0]; a is the shifted operand; sra replicates a[WIDTH-1].
REQ-018 add/sub wrap modulo 2^WIDTH; no overflow flag; slt/sltu yield 1 or 0 zero-extended to WIDTH.
REQ-019 FSM states IDLE, MUL, DONE; reset state IDLE.
REQ-020 IDLE, start=1, non-multiply op: result, hi=0, zero, illegal registered at that edge; next state DONE.
REQ-021 IDLE, start=1, multu: operands latched, 2*WIDTH-bit accumulator cleared, counter loaded with WIDTH; next state MUL.
REQ-022 MUL: one shift-add step per cycle, multiplier LSB first; counter decrements; on last step result/hi/zero load and next state DONE.
REQ-023 DONE: done=1 for exactly one cycle; next state IDLE unconditionally.
REQ-024 Latency: done high in the cycle after the accepting edge for single-cycle ops; WIDTH+1 cycles after for multu.
REQ-025 Illegal requests take the single-cycle path: result=0, hi=0, zero=1, illegal=1.
REQ-026 start while busy=1 is ignored with no side effect; maximum issue rate one request every 2 cycles.
REQ-027 a, b, aluop, funct changes after the accepting edge do not affect the operation in flight.
REQ-028 result, hi, zero, illegal hold their values between completions.

Reset
REQ-029 reset=1 forces IDLE immediately, independent of clk, aborting any operation in flight.
REQ-030 Reset values: result=0, hi=0, zero=0, busy=0, done=0, illegal=0, counter=0, accumulator=0.
REQ-031 After reset release, the first rising edge accepts start normally.

Structure
REQ-032 Package alu_pkg holds the op enum (ADD, SUB, AND, OR, XOR, NOR, SLT, SLTU, SLL, SRL, SRA, MULTU, ILL), the aluop and funct code constants, and the FSM state typedef.
REQ-033 Single sub-module alu_op_core: purely combinational, (op, a, b) -> WIDTH result, shared by all single-cycle ops; the decode and multiply sequencer stay in alu_seq_unit.

Verification
REQ-034 WIDTH=32, aluop=10 funct=100010, a=5, b=7 -> done in cycle after start, result=32'hFFFFFFFE, zero=0, illegal=0.
REQ-035 aluop=10 funct=011001, a=32'hFFFFFFFF, b=2 -> busy for 33 cycles, done on cycle 33, hi=1, result=32'hFFFFFFFE; start pulses mid-multiply ignored.
REQ-036 aluop=10 funct=000011, a=32'h80000000, b=4 -> result=32'hF8000000; funct=101010, a=-1, b=1 -> result=1; funct=101011 same operands -> result=0.
REQ-037 aluop=11, then aluop=10 funct=111111, then MUL_EN=0 build with multu -> each gives done with illegal=1, result=0, zero=1 one cycle after start.
REQ-038 reset asserted mid-multiply, between clock edges -> busy=0, done=0, result=0 immediately; next start aluop=00 a=3 b=4 -> result=7.
REQ-039 WIDTH=8, aluop=00 a=8'hFF b=1 -> result=0, zero=1; sll with b=9 -> shift amount 1.
